// File: rtl/tlp_fifo_arbiter_pkg.sv
// Shared transaction-layer definitions: source count, byte width,
// burst limit and the read-scheduler FSM encoding.
package tlp_fifo_arbiter_pkg;

    localparam int NUM_SRC   = 4;
    localparam int DATA_W    = 8;
    localparam int BURST_MAX = 16;

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } arb_state_e;

    function automatic logic [NUM_SRC-1:0] onehot4(input logic [1:0] idx);
        onehot4      = '0;
        onehot4[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/tlp_fifo_arbiter_rr_pick4.sv
// Combinational round-robin picker over four requesters.
// Ports: req[3:0] requests, last[1:0] previous winner,
//        idx[1:0] next winner (scan last+1 .. last+4), any = |req.
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] last,
    output logic [1:0] idx,
    output logic       any
);

    logic [1:0] base;
    logic [7:0] req2;
    logic [3:0] rot;

    // rot[j] is the request of source (last + 1 + j) mod 4
    assign base = last + 2'd1;
    assign req2 = {req, req};
    assign rot  = req2[base +: 4];
    assign any  = |req;

    always_comb begin
        idx = last;
        priority case (1'b1)
            rot[0]:  idx = base;
            rot[1]:  idx = base + 2'd1;
            rot[2]:  idx = base + 2'd2;
            rot[3]:  idx = base + 2'd3;
            default: idx = last;
        endcase
    end

endmodule

// File: rtl/tlp_fifo_arbiter.sv
// Round-robin burst read scheduler: four source FIFOs onto one TLP byte path.
// Ports: clk, rst_n (async, active-low); src_empty/src_en[3:0], src_data[31:0]
//        in; out_afull in; src_rd[3:0], out_wr, out_data[7:0], grant[1:0], busy out.
module tlp_fifo_arbiter
    import tlp_fifo_arbiter_pkg::*;
#(
    parameter int BURST = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  src_empty,
    input  logic [31:0] src_data,
    input  logic [3:0]  src_en,
    input  logic        out_afull,
    output logic [3:0]  src_rd,
    output logic        out_wr,
    output logic [7:0]  out_data,
    output logic [1:0]  grant,
    output logic        busy
);

    arb_state_e state;
    arb_state_e state_nxt;

    logic [1:0] grant_nxt;
    logic [1:0] last;
    logic [1:0] last_nxt;
    logic [1:0] grant_d;
    logic [3:0] cnt;
    logic [3:0] cnt_nxt;
    logic [3:0] req;
    logic [1:0] pick_idx;
    logic       pick_any;
    logic       issue;
    logic       last_beat;

    assign req = ~src_empty & src_en;

    rr_pick4 u_pick (
        .req  (req),
        .last (last),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    // Terminal issue is detected one count early so that BURST = 16
    // still fits the 4-bit counter.
    assign last_beat = (cnt == 4'(BURST - 1));

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        last_nxt  = last;
        cnt_nxt   = cnt;
        issue     = 1'b0;
        unique case (state)
            IDLE: begin
                if (pick_any) begin
                    grant_nxt = pick_idx;
                    cnt_nxt   = 4'd0;
                    state_nxt = READ;
                end
            end
            READ: begin
                issue = ~src_empty[grant] & src_en[grant] & ~out_afull;
                if (issue && !last_beat) begin
                    cnt_nxt = cnt + 4'd1;
                end
                // out_afull only stalls; it never ends the grant
                if ((issue && last_beat) || src_empty[grant] || !src_en[grant]) begin
                    state_nxt = IDLE;
                    last_nxt  = grant;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            grant   <= 2'd0;
            last    <= 2'd3;
            cnt     <= 4'd0;
            out_wr  <= 1'b0;
            grant_d <= 2'd0;
        end else begin
            state   <= state_nxt;
            grant   <= grant_nxt;
            last    <= last_nxt;
            cnt     <= cnt_nxt;
            out_wr  <= issue;
            grant_d <= grant;
        end
    end

    // Sources have a registered read port: the byte popped at t is on
    // src_data at t+1, aligned with out_wr through grant_d.
    assign src_rd   = issue ? onehot4(grant) : 4'd0;
    assign out_data = src_data[grant_d * DATA_W +: DATA_W];
    assign busy     = (state == READ);

endmodule

// File: tb/tb_tlp_fifo_arbiter.sv
// Self-checking bench for tlp_fifo_arbiter with modelled registered-read
// source FIFOs and a byte scoreboard.
module tb_tlp_fifo_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  src_empty;
    logic [31:0] src_data;
    logic [3:0]  src_en = 4'hF;
    logic        out_afull = 1'b0;
    logic [3:0]  src_rd;
    logic        out_wr;
    logic [7:0]  out_data;
    logic [1:0]  grant;
    logic        busy;

    int checks = 0;
    int failures = 0;

    logic [7:0] q [4][$];
    logic [7:0] exp_src [4][$];
    logic [7:0] sb [$];
    logic [7:0] dout [4] = '{8'h5A, 8'h00, 8'h00, 8'h00};
    logic [3:0] empty_r = 4'hF;

    assign src_empty = empty_r;
    assign src_data  = {dout[3], dout[2], dout[1], dout[0]};

    always #5 clk = ~clk;

    tlp_fifo_arbiter #(.BURST(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .src_empty (src_empty),
        .src_data  (src_data),
        .src_en    (src_en),
        .out_afull (out_afull),
        .src_rd    (src_rd),
        .out_wr    (out_wr),
        .out_data  (out_data),
        .grant     (grant),
        .busy      (busy)
    );

    // Source FIFO model: registered read, writes visible one edge later.
    always @(posedge clk) begin
        logic [7:0] b;
        for (int k = 0; k < 4; k++) begin
            if (src_rd[k] && q[k].size() > 0) begin
                b = q[k].pop_front();
                dout[k] <= b;
            end
        end
        for (int k = 0; k < 4; k++) empty_r[k] <= (q[k].size() == 0);
    end

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (src_rd !== 4'd0) begin
            failures++; $display("FAIL reset_src_rd got=%0h exp=0", src_rd);
        end
        checks++;
        if (out_wr !== 1'b0) begin
            failures++; $display("FAIL reset_out_wr got=%0b exp=0", out_wr);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL reset_busy got=%0b exp=0", busy);
        end
        checks++;
        if (grant !== 2'd0) begin
            failures++; $display("FAIL reset_grant got=%0d exp=0", grant);
        end
        checks++;
        if (out_data !== 8'h5A) begin
            failures++; $display("FAIL reset_out_data got=%0h exp=5a", out_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_two_sources();
        logic [1:0] gseq [$];
        logic [7:0] e;
        bit prev_busy = 1'b0;
        int idle_run = 0;
        for (int i = 0; i < 6; i++) begin
            q[0].push_back(8'h10 + 8'(i));
            q[2].push_back(8'h20 + 8'(i));
        end
        for (int i = 0; i < 4; i++) sb.push_back(8'h10 + 8'(i));
        for (int i = 0; i < 4; i++) sb.push_back(8'h20 + 8'(i));
        for (int i = 4; i < 6; i++) sb.push_back(8'h10 + 8'(i));
        for (int i = 4; i < 6; i++) sb.push_back(8'h20 + 8'(i));
        for (int c = 0; c < 60 && sb.size() > 0; c++) begin
            @(negedge clk);
            #1;
            if (busy && !prev_busy) begin
                if (gseq.size() > 0) begin
                    checks++;
                    if (idle_run != 1) begin
                        failures++; $display("FAIL rr_idle_gap got=%0d exp=1", idle_run);
                    end
                end
                gseq.push_back(grant);
            end
            if (!busy && gseq.size() > 0) idle_run = prev_busy ? 1 : idle_run + 1;
            if (out_wr) begin
                checks++;
                e = sb.pop_front();
                if (out_data !== e) begin
                    failures++; $display("FAIL rr_data got=%0h exp=%0h", out_data, e);
                end
            end
            prev_busy = busy;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++; $display("FAIL rr_timeout got=%0d exp=0 left", sb.size());
        end
        checks++;
        if (gseq.size() != 4 || gseq[0] !== 2'd0 || gseq[1] !== 2'd2 ||
            gseq[2] !== 2'd0 || gseq[3] !== 2'd2) begin
            failures++; $display("FAIL rr_grant_seq got=%0d grants exp=0,2,0,2", gseq.size());
        end
        sb.delete();
        repeat (4) @(negedge clk);
    endtask

    task automatic test_short_grant();
        logic [7:0] e;
        bit bad = 1'b0;
        bit prev_busy = 1'b0;
        int nrd = 0;
        logic [1:0] first_g = 2'd0;
        bit got_g = 1'b0;
        q[1].push_back(8'h30);
        q[1].push_back(8'h31);
        sb.push_back(8'h30);
        sb.push_back(8'h31);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            #1;
            if (src_rd[1] && src_empty[1]) bad = 1'b1;
            if (src_rd[1]) nrd++;
            if (out_wr) begin
                checks++;
                e = sb.size() > 0 ? sb.pop_front() : 8'hxx;
                if (out_data !== e) begin
                    failures++; $display("FAIL short_data got=%0h exp=%0h", out_data, e);
                end
            end
        end
        checks++;
        if (bad) begin
            failures++; $display("FAIL short_rd_on_empty got=1 exp=0");
        end
        checks++;
        if (nrd != 2) begin
            failures++; $display("FAIL short_reads got=%0d exp=2", nrd);
        end
        checks++;
        if (busy !== 1'b0 || grant !== 2'd1) begin
            failures++; $display("FAIL short_end got=busy%0b/g%0d exp=busy0/g1", busy, grant);
        end
        // last = 1, so source 2 must win over source 0
        q[0].push_back(8'h41);
        q[2].push_back(8'h40);
        sb.push_back(8'h40);
        sb.push_back(8'h41);
        for (int c = 0; c < 20 && sb.size() > 0; c++) begin
            @(negedge clk);
            #1;
            if (busy && !prev_busy && !got_g) begin
                got_g = 1'b1;
                first_g = grant;
            end
            if (out_wr) begin
                checks++;
                e = sb.pop_front();
                if (out_data !== e) begin
                    failures++; $display("FAIL short_next_data got=%0h exp=%0h", out_data, e);
                end
            end
            prev_busy = busy;
        end
        checks++;
        if (!got_g || first_g !== 2'd2) begin
            failures++; $display("FAIL short_last got=%0d exp=2", first_g);
        end
        checks++;
        if (sb.size() != 0) begin
            failures++; $display("FAIL short_timeout got=%0d exp=0 left", sb.size());
        end
        sb.delete();
        repeat (4) @(negedge clk);
    endtask

    task automatic test_afull_stall();
        logic [7:0] e;
        int nrd = 0;
        int stall = 0;
        bit done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            q[3].push_back(8'h50 + 8'(i));
            sb.push_back(8'h50 + 8'(i));
        end
        for (int c = 0; c < 50 && sb.size() > 0; c++) begin
            @(negedge clk);
            if (nrd == 2 && stall == 0 && !done) begin
                out_afull = 1'b1;
                stall = 1;
            end else if (stall > 0 && stall < 5) begin
                stall++;
            end else if (stall == 5) begin
                out_afull = 1'b0;
                stall = 0;
                done = 1'b1;
            end
            #1;
            if (stall > 0) begin
                checks++;
                if (src_rd !== 4'd0) begin
                    failures++; $display("FAIL stall_src_rd got=%0h exp=0", src_rd);
                end
                checks++;
                if (busy !== 1'b1) begin
                    failures++; $display("FAIL stall_busy got=%0b exp=1", busy);
                end
                if (stall >= 2) begin
                    checks++;
                    if (out_wr !== 1'b0) begin
                        failures++; $display("FAIL stall_out_wr got=%0b exp=0", out_wr);
                    end
                end
            end
            if (src_rd != 4'd0) nrd++;
            if (out_wr) begin
                checks++;
                e = sb.pop_front();
                if (out_data !== e) begin
                    failures++; $display("FAIL stall_data got=%0h exp=%0h", out_data, e);
                end
            end
        end
        checks++;
        if (sb.size() != 0 || !done) begin
            failures++; $display("FAIL stall_timeout got=%0d exp=0 left", sb.size());
        end
        out_afull = 1'b0;
        sb.delete();
        repeat (4) @(negedge clk);
    endtask

    task automatic test_enable_mask();
        logic [1:0] gseq [$];
        logic [1:0] eg [6] = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3};
        logic [7:0] base [4] = '{8'h60, 8'h70, 8'h80, 8'h90};
        logic [7:0] e;
        bit prev_busy = 1'b0;
        bit rd2 = 1'b0;
        bit seq_ok;
        src_en = 4'b1011;
        for (int k = 0; k < 4; k++)
            for (int i = 0; i < 8; i++) q[k].push_back(base[k] + 8'(i));
        for (int h = 0; h < 2; h++)
            for (int g = 0; g < 6; g++)
                if (g != 2 && g != 4 && g != 5) begin
                end
        for (int h = 0; h < 2; h++)
            for (int j = 0; j < 3; j++)
                for (int i = 0; i < 4; i++)
                    sb.push_back(base[eg[j]] + 8'(4 * h + i));
        for (int c = 0; c < 100 && sb.size() > 0; c++) begin
            @(negedge clk);
            #1;
            if (src_rd[2]) rd2 = 1'b1;
            if (busy && !prev_busy) gseq.push_back(grant);
            if (out_wr) begin
                checks++;
                e = sb.pop_front();
                if (out_data !== e) begin
                    failures++; $display("FAIL mask_data got=%0h exp=%0h", out_data, e);
                end
            end
            prev_busy = busy;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++; $display("FAIL mask_timeout got=%0d exp=0 left", sb.size());
        end
        seq_ok = (gseq.size() == 6);
        for (int i = 0; i < 6 && seq_ok; i++) if (gseq[i] !== eg[i]) seq_ok = 1'b0;
        checks++;
        if (!seq_ok) begin
            failures++; $display("FAIL mask_grant_seq got=%0d grants exp=0,1,3,0,1,3", gseq.size());
        end
        checks++;
        if (rd2) begin
            failures++; $display("FAIL mask_src2_read got=1 exp=0");
        end
        repeat (4) @(negedge clk);
        q[2].delete();
        repeat (2) @(negedge clk);
        src_en = 4'hF;
        sb.delete();
    endtask

    task automatic test_reset_mid();
        logic [7:0] e;
        int nrd = 0;
        bit prev_busy = 1'b0;
        bit got_g = 1'b0;
        logic [1:0] first_g = 2'd3;
        q[0].push_back(8'hB0);
        sb.push_back(8'hB0);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            if (out_wr) begin
                checks++;
                e = sb.size() > 0 ? sb.pop_front() : 8'hxx;
                if (out_data !== e) begin
                    failures++; $display("FAIL rstmid_pre_data got=%0h exp=%0h", out_data, e);
                end
            end
        end
        for (int i = 0; i < 4; i++) q[1].push_back(8'hD0 + 8'(i));
        sb.push_back(8'hD0);
        for (int c = 0; c < 20 && nrd < 2; c++) begin
            @(negedge clk);
            #1;
            if (out_wr) begin
                checks++;
                e = sb.size() > 0 ? sb.pop_front() : 8'hxx;
                if (out_data !== e) begin
                    failures++; $display("FAIL rstmid_d0 got=%0h exp=%0h", out_data, e);
                end
            end
            if (src_rd[1]) begin
                nrd++;
                if (nrd == 1) begin
                    q[0].push_back(8'hE0);
                    q[2].push_back(8'hF0);
                end
            end
        end
        checks++;
        if (nrd != 2) begin
            failures++; $display("FAIL rstmid_no_second_read got=%0d exp=2", nrd);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (src_rd !== 4'd0 || out_wr !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_clear got=rd%0h/wr%0b/busy%0b exp=0/0/0", src_rd, out_wr, busy);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        sb.push_back(8'hE0);
        for (int i = 1; i < 4; i++) sb.push_back(8'hD0 + 8'(i));
        sb.push_back(8'hF0);
        for (int c = 0; c < 40 && sb.size() > 0; c++) begin
            @(negedge clk);
            #1;
            if (busy && !prev_busy && !got_g) begin
                got_g = 1'b1;
                first_g = grant;
            end
            if (out_wr) begin
                checks++;
                e = sb.pop_front();
                if (out_data !== e) begin
                    failures++; $display("FAIL rstmid_post_data got=%0h exp=%0h", out_data, e);
                end
            end
            prev_busy = busy;
        end
        checks++;
        if (!got_g || first_g !== 2'd0) begin
            failures++; $display("FAIL rstmid_first_grant got=%0d exp=0", first_g);
        end
        checks++;
        if (sb.size() != 0) begin
            failures++; $display("FAIL rstmid_timeout got=%0d exp=0 left", sb.size());
        end
        sb.delete();
        repeat (4) @(negedge clk);
    endtask

    task automatic test_random();
        logic [7:0] b;
        logic [7:0] e;
        bit prev_afull = 1'b0;
        int prev_src = -1;
        int left;
        for (int k = 0; k < 4; k++) begin
            q[k].delete();
            exp_src[k].delete();
        end
        src_en = 4'hF;
        out_afull = 1'b0;
        repeat (3) @(negedge clk);
        for (int c = 0; c < 10600; c++) begin
            @(negedge clk);
            if (c < 10000) begin
                for (int k = 0; k < 4; k++) begin
                    if (q[k].size() < 32 && $urandom_range(0, 99) < 12) begin
                        b = 8'($urandom);
                        q[k].push_back(b);
                        exp_src[k].push_back(b);
                    end
                end
                out_afull = ($urandom_range(0, 99) < 25);
                if ($urandom_range(0, 99) < 3)
                    src_en = 4'($urandom_range(0, 15)) | 4'($urandom_range(0, 15));
            end else begin
                out_afull = 1'b0;
                src_en = 4'hF;
            end
            #1;
            if (out_wr) begin
                checks++;
                if (prev_afull) begin
                    failures++; $display("FAIL rand_wr_on_afull got=1 exp=0 cyc=%0d", c);
                end
                checks++;
                if (prev_src < 0 || exp_src[prev_src].size() == 0) begin
                    failures++; $display("FAIL rand_wr_no_read got=%0h exp=none cyc=%0d", out_data, c);
                end else begin
                    e = exp_src[prev_src].pop_front();
                    if (out_data !== e) begin
                        failures++;
                        $display("FAIL rand_order got=%0h exp=%0h src=%0d", out_data, e, prev_src);
                    end
                end
            end else if (prev_src >= 0) begin
                checks++;
                failures++;
                $display("FAIL rand_lost_byte got=0 exp=1 src=%0d", prev_src);
            end
            checks++;
            if ((src_rd & src_empty) != 4'd0 || (src_rd & ~src_en) != 4'd0 ||
                $countones(src_rd) > 1) begin
                failures++;
                $display("FAIL rand_rd_illegal got=%0h exp=legal empty=%0h en=%0h", src_rd, src_empty, src_en);
            end
            prev_afull = out_afull;
            prev_src = -1;
            for (int k = 0; k < 4; k++) if (src_rd[k]) prev_src = k;
            left = 0;
            for (int k = 0; k < 4; k++) left += exp_src[k].size();
            if (c >= 10000 && left == 0 && prev_src < 0 && !out_wr) break;
        end
        left = 0;
        for (int k = 0; k < 4; k++) left += exp_src[k].size();
        checks++;
        if (left != 0) begin
            failures++; $display("FAIL rand_drain_timeout got=%0d exp=0 left", left);
        end
    endtask

    initial begin
        test_reset();
        test_two_sources();
        test_short_grant();
        test_afull_stall();
        test_enable_mask();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
